// File: rtl/instr_loader_if.sv
// Loader bus: byte-stream handshake from the host link plus the instruction
// memory word-write port. master = host/memory side, slave = loader.
`timescale 1ns/1ps
interface instr_loader_if #(
    parameter int unsigned LEN_WORD      = 32,
    parameter int unsigned SIZE_MEM_CELL = 8
);
    logic                     in_valid;
    logic [SIZE_MEM_CELL-1:0] in_data;
    logic                     in_ready;
    logic                     mem_write_en;
    logic [LEN_WORD-1:0]      mem_address;
    logic [LEN_WORD-1:0]      mem_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_write_en, mem_address, mem_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_write_en, mem_address, mem_data
    );
endinterface

// File: rtl/instr_loader.sv
// Boot-time program loader: assembles big-endian words from a byte stream,
// writes them to instruction memory from address 0 and verifies an XOR checksum.
`timescale 1ns/1ps
module instr_loader #(
    parameter int unsigned LEN_WORD      = 32,
    parameter int unsigned SIZE_MEM_CELL = 8,
    parameter int unsigned SIZE_MEM      = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    instr_loader_if.slave        bus,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error
);
    localparam int unsigned BYTES_PER_WORD = LEN_WORD / SIZE_MEM_CELL;
    localparam int unsigned BC_W           = $clog2(BYTES_PER_WORD);
    localparam int unsigned CNT_W          = 2 * SIZE_MEM_CELL;
    localparam int unsigned PART_W         = LEN_WORD - SIZE_MEM_CELL;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                   state, state_nxt;
    logic [SIZE_MEM_CELL-1:0] count_hi;
    logic [SIZE_MEM_CELL-1:0] checksum;
    logic [CNT_W-1:0]         word_total;
    logic [CNT_W-1:0]         word_cnt;
    logic [BC_W-1:0]          byte_cnt;
    logic [PART_W-1:0]        partial;

    logic                     ready;
    logic                     xfer;
    logic [CNT_W-1:0]         hdr_count;
    logic                     overflow;
    logic                     word_end;
    logic                     last_word;

    always_comb begin
        ready     = 1'b0;
        cpu_hold  = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        state_nxt = state;

        case (state)
            S_HDR_HI, S_HDR_LO, S_DATA, S_CHECK: ready = 1'b1;
            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            S_ERROR: error = 1'b1;
            default: ;
        endcase

        xfer      = bus.in_valid & ready;
        hdr_count = {count_hi, bus.in_data};
        // Header size check done in 32 bits so large counts cannot wrap.
        overflow  = (32'(hdr_count) * 32'(BYTES_PER_WORD)) > 32'(SIZE_MEM);
        word_end  = byte_cnt == BC_W'(BYTES_PER_WORD - 1);
        last_word = (word_cnt + CNT_W'(1)) == word_total;

        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_HDR_HI;
            S_HDR_HI: if (xfer) state_nxt = S_HDR_LO;
            S_HDR_LO: if (xfer) begin
                if (overflow)
                    state_nxt = S_ERROR;
                else if (hdr_count == '0)
                    state_nxt = S_CHECK;
                else
                    state_nxt = S_DATA;
            end
            S_DATA: if (xfer && word_end && last_word) state_nxt = S_CHECK;
            S_CHECK: if (xfer) state_nxt = (bus.in_data == checksum) ? S_DONE : S_ERROR;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.in_ready = ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= S_IDLE;
            count_hi         <= '0;
            checksum         <= '0;
            word_total       <= '0;
            word_cnt         <= '0;
            byte_cnt         <= '0;
            partial          <= '0;
            bus.mem_write_en <= 1'b0;
            bus.mem_address  <= '0;
            bus.mem_data     <= '0;
        end else begin
            state            <= state_nxt;
            bus.mem_write_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: if (start) begin
                    count_hi   <= '0;
                    checksum   <= '0;
                    word_total <= '0;
                    word_cnt   <= '0;
                    byte_cnt   <= '0;
                end
                S_HDR_HI: if (xfer) begin
                    count_hi <= bus.in_data;
                    checksum <= checksum ^ bus.in_data;
                end
                S_HDR_LO: if (xfer) begin
                    word_total <= hdr_count;
                    checksum   <= checksum ^ bus.in_data;
                end
                S_DATA: if (xfer) begin
                    checksum <= checksum ^ bus.in_data;
                    partial  <= {partial[PART_W-SIZE_MEM_CELL-1:0], bus.in_data};
                    byte_cnt <= byte_cnt + BC_W'(1);
                    if (word_end) begin
                        bus.mem_write_en <= 1'b1;
                        bus.mem_address  <= LEN_WORD'(word_cnt) << BC_W;
                        bus.mem_data     <= {partial, bus.in_data};
                        word_cnt         <= word_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed and random loads compared against a
// byte-stream reference model (expected writes, timing and final status).
`timescale 1ns/1ps
module tb_instr_loader;
    localparam int unsigned LEN_WORD      = 32;
    localparam int unsigned SIZE_MEM_CELL = 8;
    localparam int unsigned SIZE_MEM      = 256;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_hold;
    logic done;
    logic error;

    instr_loader_if #(.LEN_WORD(LEN_WORD), .SIZE_MEM_CELL(SIZE_MEM_CELL)) bus ();

    instr_loader #(
        .LEN_WORD(LEN_WORD),
        .SIZE_MEM_CELL(SIZE_MEM_CELL),
        .SIZE_MEM(SIZE_MEM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bus(bus),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    wr_t         exp_q[$];
    logic [7:0]  stream[$];
    int unsigned acc_cyc[$];
    int          consumed;
    bit          exp_done;
    bit          hold_bad;
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk)
        if (bus.mem_write_en === 1'b1) wq.push_back('{cyc, bus.mem_address, bus.mem_data});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decode the stream by its format rules into writes and outcome.
    task automatic model();
        int n;
        logic [7:0] x;
        exp_q.delete();
        n = int'({stream[0], stream[1]});
        if (n * 4 > int'(SIZE_MEM)) begin
            consumed = 2;
            exp_done = 1'b0;
            return;
        end
        for (int k = 0; k < n; k++)
            exp_q.push_back('{0, 32'(4 * k),
                {stream[2+4*k], stream[3+4*k], stream[4+4*k], stream[5+4*k]}});
        consumed = 2 + 4 * n + 1;
        x = 8'h00;
        for (int i = 0; i < consumed - 1; i++) x ^= stream[i];
        exp_done = (stream[consumed-1] == x);
    endtask

    task automatic build(input int unsigned n, input bit good);
        logic [7:0] x;
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        if (n * 4 <= SIZE_MEM) begin
            repeat (4 * n) stream.push_back(8'($urandom));
            x = 8'h00;
            foreach (stream[i]) x ^= stream[i];
            stream.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
        end
    endtask

    task automatic do_start();
        wq.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_in_ready", 64'(bus.in_ready), 64'(1));
        chk("start_hold", 64'(cpu_hold), 64'(1));
        chk("start_done_clr", 64'(done), 64'(0));
        chk("start_err_clr", 64'(error), 64'(0));
    endtask

    task automatic drive(input int n, input int unsigned bubble, input int start_at);
        int i = 0;
        int guard = 0;
        acc_cyc.delete();
        hold_bad = 1'b0;
        while (i < n && guard < 4000) begin
            @(negedge clk);
            guard++;
            bus.in_valid = ($urandom_range(99) >= bubble);
            bus.in_data  = stream[i];
            start        = (i == start_at);
            #2;
            if (cpu_hold !== 1'b1) hold_bad = 1'b1;
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                acc_cyc.push_back(cyc + 1);
                i++;
            end
            @(posedge clk);
        end
        #1;
        bus.in_valid = 1'b0;
        start        = 1'b0;
        chk("accept_all", 64'(i), 64'(n));
    endtask

    task automatic run_load(input int unsigned bubble, input int start_at);
        model();
        do_start();
        drive(consumed, bubble, start_at);
        chk("hold_during_load", 64'(hold_bad), 64'(0));
        chk("done", 64'(done), 64'(exp_done));
        chk("error", 64'(error), 64'(!exp_done));
        chk("cpu_hold", 64'(cpu_hold), 64'(!exp_done));
        chk("in_ready_end", 64'(bus.in_ready), 64'(0));
        chk("write_count", 64'(wq.size()), 64'(exp_q.size()));
        for (int k = 0; k < wq.size() && k < exp_q.size(); k++) begin
            chk($sformatf("wr_addr%0d", k), 64'(wq[k].addr), 64'(exp_q[k].addr));
            chk($sformatf("wr_data%0d", k), 64'(wq[k].data), 64'(exp_q[k].data));
            if (5 + 4 * k < acc_cyc.size())
                chk($sformatf("wr_cyc%0d", k), 64'(wq[k].cyc), 64'(acc_cyc[5+4*k]));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sticky_done", 64'(done), 64'(exp_done));
        chk("sticky_error", 64'(error), 64'(!exp_done));
        chk("no_late_write", 64'(wq.size()), 64'(exp_q.size()));
    endtask

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", 64'(cpu_hold), 64'(1));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_error", 64'(error), 64'(0));
        chk("rst_wr_en", 64'(bus.mem_write_en), 64'(0));
        chk("rst_addr", 64'(bus.mem_address), 64'(0));
        chk("rst_data", 64'(bus.mem_data), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // Two-word program; final byte is the XOR of the ten bytes before it.
        stream = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05,
                   8'h8C, 8'h09, 8'h00, 8'h04, 8'hAA};
        run_load(0, -1);
        run_load(40, 5);
        stream[10] = 8'h0A;
        run_load(0, -1);

        stream = '{8'h00, 8'h41};
        run_load(0, -1);
        stream = '{8'h00, 8'h00, 8'h00};
        run_load(0, -1);
        build(64, 1'b1);
        run_load(10, -1);
        build(65, 1'b1);
        run_load(0, -1);

        // Abort after six data bytes, then a clean reload.
        stream = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05,
                   8'h8C, 8'h09, 8'h00, 8'h04, 8'hAA};
        model();
        do_start();
        drive(8, 0, -1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_hold", 64'(cpu_hold), 64'(1));
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_error", 64'(error), 64'(0));
        chk("mid_rst_data", 64'(bus.mem_data), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        run_load(0, -1);

        for (int r = 0; r < 8; r++) begin
            int unsigned n;
            n = $urandom_range(0, 8);
            build(n, $urandom_range(0, 3) != 0);
            run_load(30, (n > 0) ? 2 + int'($urandom_range(0, 4 * n - 1)) : -1);
        end
        for (int r = 0; r < 2; r++) begin
            build($urandom_range(65, 65535), 1'b1);
            run_load(20, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
